// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage with IF/ID output register, 1-entry skid buffer and
// req/ack instruction-memory handshake with branch redirect and in-flight drop.
module if_fetch_stage #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hazard,
  input  logic              freeze,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              valid,
  output logic [31:0]       instruction,
  output logic [ADDR_W-1:0] pc_out
);

  typedef enum logic [1:0] {
    S_REQ,
    S_IDLE,
    S_DROP
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] redirect;

  logic              skid_valid;
  logic [31:0]       skid_instr;
  logic [ADDR_W-1:0] skid_pc;

  logic              stall;
  logic              ack_ok;
  logic              accept;
  logic [ADDR_W-1:0] pc_inc;

  logic              valid_n;
  logic [31:0]       instr_n;
  logic [ADDR_W-1:0] pc_out_n;
  logic              skid_valid_n;
  logic [31:0]       skid_instr_n;
  logic [ADDR_W-1:0] skid_pc_n;

  // NOTE: rst is folded in combinationally so the request drops the instant
  // reset asserts, not at the next clock edge.
  assign imem_req  = !rst && (state != S_IDLE);
  assign imem_addr = pc;
  assign stall     = hazard | freeze;
  assign ack_ok    = imem_req & imem_ack;
  assign accept    = (state == S_REQ) && ack_ok && !branch_taken;
  assign pc_inc    = pc + ADDR_W'(PC_STEP);

  // Next value of the IF/ID register and skid buffer.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves one unassigned
    // and no latch is inferred.
    valid_n      = valid;
    instr_n      = instruction;
    pc_out_n     = pc_out;
    skid_valid_n = skid_valid;
    skid_instr_n = skid_instr;
    skid_pc_n    = skid_pc;

    if (branch_taken) begin
      valid_n      = 1'b0;
      skid_valid_n = 1'b0;
    end else if (!stall || !valid) begin
      if (skid_valid) begin
        valid_n      = 1'b1;
        instr_n      = skid_instr;
        pc_out_n     = skid_pc;
        skid_valid_n = accept;
        if (accept) begin
          skid_instr_n = imem_rdata;
          skid_pc_n    = pc_inc;
        end
      end else if (accept) begin
        valid_n  = 1'b1;
        instr_n  = imem_rdata;
        pc_out_n = pc_inc;
      end else begin
        valid_n = 1'b0;
      end
    end else if (accept) begin
      // Output is held by the stall; park the arriving word.
      skid_valid_n = 1'b1;
      skid_instr_n = imem_rdata;
      skid_pc_n    = pc_inc;
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      redirect    <= '0;
      valid       <= 1'b0;
      instruction <= '0;
      pc_out      <= '0;
      skid_valid  <= 1'b0;
      skid_instr  <= '0;
      skid_pc     <= '0;
    end else begin
      valid       <= valid_n;
      instruction <= instr_n;
      pc_out      <= pc_out_n;
      skid_valid  <= skid_valid_n;
      skid_instr  <= skid_instr_n;
      skid_pc     <= skid_pc_n;

      unique case (state)
        S_REQ: begin
          if (ack_ok && branch_taken) begin
            pc <= branch_addr;
          end else if (ack_ok) begin
            pc    <= pc_inc;
            state <= skid_valid_n ? S_IDLE : S_REQ;
          end else if (branch_taken) begin
            redirect <= branch_addr;
            state    <= S_DROP;
          end
        end
        S_IDLE: begin
          if (branch_taken) begin
            pc    <= branch_addr;
            state <= S_REQ;
          end else if (!skid_valid_n) begin
            state <= S_REQ;
          end
        end
        S_DROP: begin
          // The in-flight word is stale; a branch in the ack cycle wins.
          if (ack_ok) begin
            pc    <= branch_taken ? branch_addr : redirect;
            state <= S_REQ;
          end else if (branch_taken) begin
            redirect <= branch_addr;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: a configurable-latency memory model answers
// requests with (address ^ 32'hE1A0_0000); expected values are hand-derived.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hazard = 1'b0;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        valid;
  logic [31:0] instruction;
  logic [31:0] pc_out;

  int vectors = 0;
  int errors  = 0;
  int lat     = 1;
  logic [7:0] cnt;

  if_fetch_stage dut (
    .clk(clk), .rst(rst), .hazard(hazard), .freeze(freeze),
    .branch_taken(branch_taken), .branch_addr(branch_addr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .valid(valid), .instruction(instruction),
    .pc_out(pc_out)
  );

  always #5 clk = ~clk;

  // Memory answers in the lat-th cycle of a request (lat=1 is zero-wait).
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       cnt <= '0;
    else if (imem_req && !imem_ack) cnt <= cnt + 8'd1;
    else                           cnt <= '0;
  end
  assign imem_ack   = imem_req && (int'(cnt) == lat - 1);
  assign imem_rdata = imem_addr ^ 32'hE1A0_0000;

  function automatic logic [31:0] f(input logic [31:0] a);
    return a ^ 32'hE1A0_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int l);
    rst = 1'b1; lat = l;
    hazard = 1'b0; freeze = 1'b0; branch_taken = 1'b0;
    step();
    check("rst_req", imem_req, 0);
    check("rst_valid", valid, 0);
    check("rst_instr", instruction, 0);
    check("rst_pcout", pc_out, 0);
    step();
    rst = 1'b0;
    #1;
    check("first_req", imem_req, 1);
    check("first_addr", imem_addr, 32'h0);
  endtask

  initial begin
    // Zero-wait streaming
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("zw_valid", valid, 1);
      check("zw_instr", instruction, f(32'(4 * i)));
      check("zw_pcout", pc_out, 32'(4 * i + 4));
    end

    // Three-cycle latency
    do_reset(3);
    step(); check("l3_addr1", imem_addr, 0); check("l3_v1", valid, 0);
    step(); check("l3_addr2", imem_addr, 0); check("l3_v2", valid, 0);
    step(); check("l3_v3", valid, 1); check("l3_i3", instruction, f(0));
    check("l3_addr3", imem_addr, 4);
    step(); check("l3_v4", valid, 0); check("l3_addr4", imem_addr, 4);
    step(); check("l3_v5", valid, 0);
    step(); check("l3_v6", valid, 1); check("l3_i6", instruction, f(4));
    check("l3_p6", pc_out, 8);

    // Hazard for 4 cycles with skid capture
    do_reset(1);
    step(); hazard = 1'b1;
    step(); check("hz_req_off", imem_req, 0); check("hz_hold", instruction, f(0));
    step(); step(); step();
    check("hz_hold_v", valid, 1); check("hz_hold_i", instruction, f(0));
    check("hz_hold_p", pc_out, 4); check("hz_req_off2", imem_req, 0);
    hazard = 1'b0;
    step(); check("hz_skid_i", instruction, f(4)); check("hz_skid_p", pc_out, 8);
    check("hz_req_on", imem_req, 1); check("hz_addr", imem_addr, 8);
    step(); check("hz_n1_i", instruction, f(8)); check("hz_n1_p", pc_out, 12);
    step(); check("hz_n2_i", instruction, f(12)); check("hz_n2_p", pc_out, 16);

    // Branch during an in-flight 2-cycle fetch of 0x8
    do_reset(2);
    step(); step(); step(); step();
    check("bd_pre_i", instruction, f(4)); check("bd_pre_addr", imem_addr, 8);
    branch_taken = 1'b1; branch_addr = 32'h100;
    step(); branch_taken = 1'b0;
    check("bd_v0", valid, 0); check("bd_stale_req", imem_req, 1);
    check("bd_stale_addr", imem_addr, 8);
    step(); check("bd_new_addr", imem_addr, 32'h100); check("bd_v1", valid, 0);
    step(); check("bd_v2", valid, 0);
    step(); check("bd_v3", valid, 1); check("bd_i3", instruction, f(32'h100));
    check("bd_p3", pc_out, 32'h104);

    // Branch coincident with stall and ack
    do_reset(2);
    step(); step(); freeze = 1'b1;
    step(); check("bs_hold_i", instruction, f(0)); check("bs_ack", imem_ack, 1);
    branch_taken = 1'b1; branch_addr = 32'h200;
    step(); branch_taken = 1'b0;
    check("bs_v0", valid, 0); check("bs_addr", imem_addr, 32'h200);
    step(); check("bs_v1", valid, 0);
    step(); check("bs_v2", valid, 1); check("bs_i2", instruction, f(32'h200));
    check("bs_p2", pc_out, 32'h204);
    freeze = 1'b0;

    // Branch with full skid while stalled: skid must be flushed
    do_reset(1);
    step(); hazard = 1'b1;
    step(); check("sf_req_off", imem_req, 0);
    branch_taken = 1'b1; branch_addr = 32'h300;
    step(); branch_taken = 1'b0; hazard = 1'b0;
    check("sf_v0", valid, 0); check("sf_req", imem_req, 1);
    check("sf_addr", imem_addr, 32'h300);
    step(); check("sf_i", instruction, f(32'h300)); check("sf_p", pc_out, 32'h304);

    // Asynchronous reset with a request outstanding
    do_reset(3);
    step(); step(); step();
    check("ar_pre_v", valid, 1); check("ar_pre_req", imem_req, 1);
    #3 rst = 1'b1;
    #1;
    check("ar_req", imem_req, 0); check("ar_valid", valid, 0);
    check("ar_instr", instruction, 0); check("ar_pcout", pc_out, 0);
    step(); rst = 1'b0; #1;
    check("ar_rel_req", imem_req, 1); check("ar_rel_addr", imem_addr, 0);
    step(); step(); step();
    check("ar_first_i", instruction, f(0)); check("ar_first_p", pc_out, 4);

    // PC wrap-around
    do_reset(1);
    branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFC;
    step(); branch_taken = 1'b0;
    check("wr_addr", imem_addr, 32'hFFFF_FFFC); check("wr_v0", valid, 0);
    step(); check("wr_i", instruction, f(32'hFFFF_FFFC));
    check("wr_p", pc_out, 0); check("wr_next", imem_addr, 0);
    step(); check("wr_i2", instruction, f(0)); check("wr_p2", pc_out, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
